// File: rtl/mem_hybr_arb_mc.sv
`default_nettype none
// ============================================================================
//  Module   : mem_hybr_arb_mc
//  Purpose  : Multi-channel hybrid SRAM port arbiter. One high-priority
//             direct SRAM-style port and NUM_LP round-robin request/grant
//             channels share a single-port SRAM macro. A starvation counter
//             forces one LP slot after MAX_STALL consecutive HP wins while
//             LP is pending. Read data returns one cycle after the grant
//             with a per-requester valid strobe.
//  Ports    : ACLK/ARESETn        - clock, async active-low reset
//             HP_*_i / HP_*_o     - HP access (cen/wen active-low) and grant,
//                                   read valid and read data
//             LP_*_i / LP_*_o     - per-channel req/wen and flat payloads,
//                                   one-hot grant and read valid, read data
//             CEN/WEN/A/D/BE/Q    - SRAM macro pins
//  Revision : 1.0 - initial release
// ============================================================================
module mem_hybr_arb_mc #(
    parameter int NUM_LP         = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int MAX_STALL      = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic                             HP_cen_i,
    input  logic                             HP_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0]        HP_addr_i,
    input  logic [DATA_WIDTH-1:0]            HP_wdata_i,
    input  logic [NUMBYTES-1:0]              HP_be_i,
    output logic                             HP_gnt_o,
    output logic                             HP_rvalid_o,
    output logic [DATA_WIDTH-1:0]            HP_Q_o,
    input  logic [NUM_LP-1:0]                LP_req_i,
    input  logic [NUM_LP-1:0]                LP_wen_i,
    input  logic [NUM_LP*MEM_ADDR_WIDTH-1:0] LP_addr_i,
    input  logic [NUM_LP*DATA_WIDTH-1:0]     LP_wdata_i,
    input  logic [NUM_LP*NUMBYTES-1:0]       LP_be_i,
    output logic [NUM_LP-1:0]                LP_gnt_o,
    output logic [NUM_LP-1:0]                LP_rvalid_o,
    output logic [DATA_WIDTH-1:0]            LP_rdata_o,
    output logic                             CEN,
    output logic                             WEN,
    output logic [MEM_ADDR_WIDTH-1:0]        A,
    output logic [DATA_WIDTH-1:0]            D,
    output logic [NUMBYTES-1:0]              BE,
    input  logic [DATA_WIDTH-1:0]            Q
);

    localparam int c_PTR_W = (NUM_LP > 1) ? $clog2(NUM_LP) : 1;
    localparam int c_CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_STALL_MAX = c_CNT_W'(MAX_STALL);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(NUM_LP - 1);

    logic [c_PTR_W-1:0]        r_rr_ptr;
    logic [c_CNT_W-1:0]        r_stall_cnt;
    logic                      r_rd_hp;
    logic [NUM_LP-1:0]         r_rd_lp;

    logic                      w_lp_any;
    logic                      w_force_lp;
    logic                      w_hp_gnt;
    logic                      w_lp_found;
    logic [c_PTR_W-1:0]        w_lp_win;
    logic [NUM_LP-1:0]         w_lp_sel;
    logic [NUM_LP-1:0]         w_lp_gnt;
    logic                      w_lp_wen;
    logic [MEM_ADDR_WIDTH-1:0] w_lp_addr;
    logic [DATA_WIDTH-1:0]     w_lp_wdata;
    logic [NUMBYTES-1:0]       w_lp_be;

    assign w_lp_any   = |LP_req_i;
    assign w_force_lp = (MAX_STALL != 0) && (r_stall_cnt == c_STALL_MAX) && w_lp_any;
    assign w_hp_gnt   = !HP_cen_i && !w_force_lp;

    // Round-robin pick: first requester at or above the pointer, else the
    // first requester from index 0 (the wrapped part of the scan).
    always_comb begin
        w_lp_found = 1'b0;
        w_lp_win   = '0;
        for (int i = 0; i < NUM_LP; i++) begin
            if (!w_lp_found && LP_req_i[i] && (i >= int'(r_rr_ptr))) begin
                w_lp_found = 1'b1;
                w_lp_win   = c_PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_LP; i++) begin
            if (!w_lp_found && LP_req_i[i]) begin
                w_lp_found = 1'b1;
                w_lp_win   = c_PTR_W'(i);
            end
        end
    end

    // One-hot winner and its payload slice.
    always_comb begin
        w_lp_sel   = '0;
        w_lp_wen   = 1'b1;
        w_lp_addr  = '0;
        w_lp_wdata = '0;
        w_lp_be    = '0;
        for (int i = 0; i < NUM_LP; i++) begin
            w_lp_sel[i] = w_lp_found && (w_lp_win == c_PTR_W'(i));
            if (w_lp_sel[i]) begin
                w_lp_wen   = LP_wen_i[i];
                w_lp_addr  = LP_addr_i[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                w_lp_wdata = LP_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_lp_be    = LP_be_i[i*NUMBYTES +: NUMBYTES];
            end
        end
    end

    assign w_lp_gnt = w_hp_gnt ? '0 : w_lp_sel;

    // SRAM pin mux; idle drives a quiet, deselected macro.
    always_comb begin
        CEN = 1'b1;
        WEN = 1'b1;
        A   = '0;
        D   = '0;
        BE  = '0;
        if (w_hp_gnt) begin
            CEN = 1'b0;
            WEN = HP_wen_i;
            A   = HP_addr_i;
            D   = HP_wdata_i;
            BE  = HP_be_i;
        end else if (w_lp_found) begin
            CEN = 1'b0;
            WEN = w_lp_wen;
            A   = w_lp_addr;
            D   = w_lp_wdata;
            BE  = w_lp_be;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_rd_hp     <= 1'b0;
            r_rd_lp     <= '0;
        end else begin
            // Explicit wrap so non-power-of-two channel counts stay in range.
            if (|w_lp_gnt) begin
                r_rr_ptr <= (w_lp_win == c_PTR_LAST) ? '0 : w_lp_win + 1'b1;
            end
            if (!w_lp_any || (|w_lp_gnt)) begin
                r_stall_cnt <= '0;
            end else if (w_hp_gnt && (r_stall_cnt != c_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            r_rd_hp <= w_hp_gnt & HP_wen_i;
            r_rd_lp <= w_lp_gnt & {NUM_LP{w_lp_wen}};
        end
    end

    assign HP_gnt_o    = w_hp_gnt;
    assign LP_gnt_o    = w_lp_gnt;
    assign HP_rvalid_o = r_rd_hp;
    assign LP_rvalid_o = r_rd_lp;
    assign HP_Q_o      = Q;
    assign LP_rdata_o  = Q;

endmodule
`default_nettype wire

// File: tb/tb_mem_hybr_arb_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_hybr_arb_mc
//  Purpose  : Directed self-checking bench for mem_hybr_arb_mc. Instance A
//             uses defaults (NUM_LP=4, MAX_STALL=8), instance Z shares A's
//             inputs with MAX_STALL=0, instance C has NUM_LP=3. Read returns
//             of instance A are checked through an expected-data queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_hybr_arb_mc;

    localparam logic [63:0] c_Q_IDLE = 64'hFFFF_0000_FFFF_0000;

    typedef struct {
        int          due;
        logic        hp;
        logic [3:0]  lp;
        logic [63:0] q;
    } rd_t;

    logic         clk = 1'b0;
    logic         ARESETn;
    logic         HP_cen, HP_wen;
    logic [12:0]  HP_addr;
    logic [63:0]  HP_wdata;
    logic [7:0]   HP_be;
    logic [3:0]   LP_req, LP_wen;
    logic [51:0]  LP_addr;
    logic [255:0] LP_wdata;
    logic [31:0]  LP_be;
    logic [63:0]  Q;

    logic         a_hp_gnt, a_hp_rvalid, a_cen, a_wen;
    logic [63:0]  a_hp_q, a_lp_rdata, a_d;
    logic [3:0]   a_lp_gnt, a_lp_rvalid;
    logic [12:0]  a_a;
    logic [7:0]   a_be;

    logic         z_hp_gnt, z_hp_rvalid, z_cen, z_wen;
    logic [63:0]  z_hp_q, z_lp_rdata, z_d;
    logic [3:0]   z_lp_gnt, z_lp_rvalid;
    logic [12:0]  z_a;
    logic [7:0]   z_be;

    logic         c_hp_cen;
    logic [2:0]   c_lp_req, c_lp_wen;
    logic [38:0]  c_lp_addr;
    logic [191:0] c_lp_wdata;
    logic [23:0]  c_lp_be;
    logic         c_hp_gnt, c_hp_rvalid, c_cen, c_wen;
    logic [63:0]  c_hp_q, c_lp_rdata, c_d;
    logic [2:0]   c_lp_gnt, c_lp_rvalid;
    logic [12:0]  c_a;
    logic [7:0]   c_be;

    int  n_checks;
    int  n_err;
    int  cyc;
    rd_t sb[$];

    always #5 clk = ~clk;

    mem_hybr_arb_mc u_dut_a (
        .ACLK(clk), .ARESETn(ARESETn),
        .HP_cen_i(HP_cen), .HP_wen_i(HP_wen), .HP_addr_i(HP_addr),
        .HP_wdata_i(HP_wdata), .HP_be_i(HP_be),
        .HP_gnt_o(a_hp_gnt), .HP_rvalid_o(a_hp_rvalid), .HP_Q_o(a_hp_q),
        .LP_req_i(LP_req), .LP_wen_i(LP_wen), .LP_addr_i(LP_addr),
        .LP_wdata_i(LP_wdata), .LP_be_i(LP_be),
        .LP_gnt_o(a_lp_gnt), .LP_rvalid_o(a_lp_rvalid), .LP_rdata_o(a_lp_rdata),
        .CEN(a_cen), .WEN(a_wen), .A(a_a), .D(a_d), .BE(a_be), .Q(Q)
    );

    mem_hybr_arb_mc #(.MAX_STALL(0)) u_dut_z (
        .ACLK(clk), .ARESETn(ARESETn),
        .HP_cen_i(HP_cen), .HP_wen_i(HP_wen), .HP_addr_i(HP_addr),
        .HP_wdata_i(HP_wdata), .HP_be_i(HP_be),
        .HP_gnt_o(z_hp_gnt), .HP_rvalid_o(z_hp_rvalid), .HP_Q_o(z_hp_q),
        .LP_req_i(LP_req), .LP_wen_i(LP_wen), .LP_addr_i(LP_addr),
        .LP_wdata_i(LP_wdata), .LP_be_i(LP_be),
        .LP_gnt_o(z_lp_gnt), .LP_rvalid_o(z_lp_rvalid), .LP_rdata_o(z_lp_rdata),
        .CEN(z_cen), .WEN(z_wen), .A(z_a), .D(z_d), .BE(z_be), .Q(Q)
    );

    mem_hybr_arb_mc #(.NUM_LP(3)) u_dut_c (
        .ACLK(clk), .ARESETn(ARESETn),
        .HP_cen_i(c_hp_cen), .HP_wen_i(HP_wen), .HP_addr_i(HP_addr),
        .HP_wdata_i(HP_wdata), .HP_be_i(HP_be),
        .HP_gnt_o(c_hp_gnt), .HP_rvalid_o(c_hp_rvalid), .HP_Q_o(c_hp_q),
        .LP_req_i(c_lp_req), .LP_wen_i(c_lp_wen), .LP_addr_i(c_lp_addr),
        .LP_wdata_i(c_lp_wdata), .LP_be_i(c_lp_be),
        .LP_gnt_o(c_lp_gnt), .LP_rvalid_o(c_lp_rvalid), .LP_rdata_o(c_lp_rdata),
        .CEN(c_cen), .WEN(c_wen), .A(c_a), .D(c_d), .BE(c_be), .Q(Q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_rd(input logic hp, input logic [3:0] lp, input logic [63:0] q);
        rd_t e;
        e.due = cyc + 1;
        e.hp  = hp;
        e.lp  = lp;
        e.q   = q;
        sb.push_back(e);
    endtask

    // Instance A read-return check: expected entry due this cycle, else quiet.
    task automatic check_rd();
        rd_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("a_hp_rvalid", 64'(a_hp_rvalid), 64'(e.hp));
            chk("a_lp_rvalid", 64'(a_lp_rvalid), 64'(e.lp));
            if (e.hp) chk("a_hp_q", a_hp_q, e.q);
            else      chk("a_lp_rdata", a_lp_rdata, e.q);
        end else begin
            chk("a_hp_rvalid_quiet", 64'(a_hp_rvalid), 64'h0);
            chk("a_lp_rvalid_quiet", 64'(a_lp_rvalid), 64'h0);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) Q = sb[0].q;
        else Q = c_Q_IDLE;
    endtask

    task automatic sample();
        @(negedge clk);
        check_rd();
    endtask

    task automatic idle_all();
        HP_cen   = 1'b1;
        HP_wen   = 1'b1;
        HP_addr  = '0;
        HP_wdata = '0;
        HP_be    = '0;
        LP_req   = '0;
        LP_wen   = '0;
        c_hp_cen = 1'b1;
        c_lp_req = '0;
        c_lp_wen = '0;
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_cen"}, 64'(a_cen), 64'h1);
        chk({tag, "_wen"}, 64'(a_wen), 64'h1);
        chk({tag, "_a"}, 64'(a_a), 64'h0);
        chk({tag, "_d"}, a_d, 64'h0);
        chk({tag, "_be"}, 64'(a_be), 64'h0);
        chk({tag, "_hp_gnt"}, 64'(a_hp_gnt), 64'h0);
        chk({tag, "_lp_gnt"}, 64'(a_lp_gnt), 64'h0);
    endtask

    initial begin
        logic [3:0] exp_g;
        bit         lp_turn;
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        ARESETn  = 1'b0;
        Q        = c_Q_IDLE;
        idle_all();
        for (int i = 0; i < 4; i++) begin
            LP_addr[i*13 +: 13]  = 13'(32'h100 + i);
            LP_wdata[i*64 +: 64] = 64'h5500_0000_0000_0000 | 64'(i);
            LP_be[i*8 +: 8]      = 8'hFF;
        end
        for (int i = 0; i < 3; i++) begin
            c_lp_addr[i*13 +: 13]  = 13'(32'h200 + i);
            c_lp_wdata[i*64 +: 64] = 64'(i);
            c_lp_be[i*8 +: 8]      = 8'hFF;
        end

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check_idle_pins("rst");
        chk("rst_c_rvalid", 64'(c_lp_rvalid), 64'h0);
        next_cycle();
        ARESETn = 1'b1;

        // Idle after reset
        sample();
        check_idle_pins("idle");
        next_cycle();

        // HP read at 0x0A5
        HP_cen = 1'b0; HP_wen = 1'b1; HP_addr = 13'h0A5;
        sample();
        chk("hp_rd_gnt", 64'(a_hp_gnt), 64'h1);
        chk("hp_rd_cen", 64'(a_cen), 64'h0);
        chk("hp_rd_wen", 64'(a_wen), 64'h1);
        chk("hp_rd_a", 64'(a_a), 64'h0A5);
        push_rd(1'b1, 4'h0, 64'hDEAD_BEEF_0000_0001);
        next_cycle();

        // HP write, be=0x0F; read data from previous cycle coexists
        HP_wen = 1'b0; HP_addr = 13'h010; HP_wdata = 64'h1122_3344_5566_7788; HP_be = 8'h0F;
        sample();
        chk("hp_wr_gnt", 64'(a_hp_gnt), 64'h1);
        chk("hp_wr_wen", 64'(a_wen), 64'h0);
        chk("hp_wr_be", 64'(a_be), 64'h0F);
        chk("hp_wr_d", a_d, 64'h1122_3344_5566_7788);
        chk("hp_wr_a", 64'(a_a), 64'h010);
        next_cycle();

        // Idle: the write must not produce rvalid
        idle_all();
        sample();
        next_cycle();

        // Reset asserted during a read grant
        HP_cen = 1'b0; HP_wen = 1'b1; HP_addr = 13'h033;
        sample();
        chk("rstrd_gnt", 64'(a_hp_gnt), 64'h1);
        ARESETn = 1'b0;
        next_cycle();
        ARESETn = 1'b1;
        idle_all();
        sample();
        next_cycle();
        sample();
        next_cycle();

        // All LP reading, HP idle: rotation 0,1,2,3,0
        LP_req = 4'hF; LP_wen = 4'hF;
        for (int k = 0; k < 5; k++) begin
            sample();
            exp_g = 4'b0001 << (k % 4);
            chk("rr_gnt", 64'(a_lp_gnt), 64'(exp_g));
            chk("rr_gnt_z", 64'(z_lp_gnt), 64'(exp_g));
            chk("rr_hp_gnt", 64'(a_hp_gnt), 64'h0);
            chk("rr_a", 64'(a_a), 64'h100 + 64'(k % 4));
            chk("rr_wen", 64'(a_wen), 64'h1);
            push_rd(1'b0, exp_g, 64'hA000 + 64'(k));
            next_cycle();
        end

        // Starvation: HP reads continuously, LP1 writes pending
        idle_all();
        HP_cen = 1'b0; HP_wen = 1'b1; HP_addr = 13'h1A0;
        LP_req = 4'b0010; LP_wen = 4'b0000;
        for (int k = 0; k < 18; k++) begin
            sample();
            lp_turn = (k == 8) || (k == 17);
            chk("stv_hp_gnt", 64'(a_hp_gnt), lp_turn ? 64'h0 : 64'h1);
            chk("stv_lp_gnt", 64'(a_lp_gnt), lp_turn ? 64'h2 : 64'h0);
            if (lp_turn) begin
                chk("stv_lp_wen", 64'(a_wen), 64'h0);
                chk("stv_lp_a", 64'(a_a), 64'h101);
            end else begin
                push_rd(1'b1, 4'h0, 64'hC000 + 64'(k));
            end
            chk("nostall_hp_gnt", 64'(z_hp_gnt), 64'h1);
            chk("nostall_lp_gnt", 64'(z_lp_gnt), 64'h0);
            next_cycle();
        end
        idle_all();
        sample();
        next_cycle();

        // NUM_LP=3: move pointer to 2, then LP0+LP2 requesting
        c_lp_req = 3'b010; c_lp_wen = 3'b111;
        sample();
        chk("c3_gnt1", 64'(c_lp_gnt), 64'h2);
        chk("c3_a1", 64'(c_a), 64'h201);
        next_cycle();
        c_lp_req = 3'b101;
        sample();
        chk("c3_gnt2", 64'(c_lp_gnt), 64'h4);
        chk("c3_a2", 64'(c_a), 64'h202);
        chk("c3_rv1", 64'(c_lp_rvalid), 64'h2);
        next_cycle();
        sample();
        chk("c3_wrap_gnt", 64'(c_lp_gnt), 64'h1);
        chk("c3_wrap_a", 64'(c_a), 64'h200);
        chk("c3_rv2", 64'(c_lp_rvalid), 64'h4);
        next_cycle();
        sample();
        chk("c3_gnt4", 64'(c_lp_gnt), 64'h4);
        chk("c3_rv3", 64'(c_lp_rvalid), 64'h1);
        chk("c3_hp_gnt", 64'(c_hp_gnt), 64'h0);
        next_cycle();
        idle_all();
        sample();
        chk("c3_rv4", 64'(c_lp_rvalid), 64'h4);
        next_cycle();
        sample();
        chk("c3_rv_quiet", 64'(c_lp_rvalid), 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
